// File: rtl/ip_pair_buffer.sv
// Source/destination IP pair buffer: captures one record per parser header-done pulse into a
// FIFO and drains each record as two 32-bit stream words (src, then dst) with registered outputs.
module ip_pair_buffer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_pkt_done,
  input  logic [31:0]           src,
  input  logic [31:0]           des_ip,
  output logic                  m_valid,
  output logic [31:0]           m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_W:0]       fifo_level,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SRC  = 2'd1,
    S_DST  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]       LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]       LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]     PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic [63:0]           mem_r [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_r;
  logic [ADDR_W-1:0]     rd_ptr_r;
  logic [ADDR_W:0]       level_r;
  logic [DROP_CNT_W-1:0] drop_cnt_r;
  logic                  overflow_r;
  state_t                state_r;
  logic                  m_valid_r;
  logic                  m_last_r;
  logic [31:0]           m_data_r;
  logic [31:0]           dst_hold_r;

  logic                  full_s;
  logic                  nonempty_s;
  logic                  wr_en_s;
  logic                  drop_s;
  logic                  hs_s;
  logic                  load_s;
  logic [63:0]           head_s;

  // Write admission, drop detection and output-stage load decision.
  always_comb begin
    full_s     = (level_r == LVL_FULL);
    nonempty_s = (level_r != {(ADDR_W + 1){1'b0}});
    wr_en_s    = rec_pkt_done && !full_s;
    drop_s     = rec_pkt_done && full_s;
    hs_s       = m_valid_r && m_ready;
    head_s     = mem_r[rd_ptr_r];
    load_s     = 1'b0;
    case (state_r)
      S_IDLE:  load_s = nonempty_s;
      S_DST:   load_s = hs_s && nonempty_s;
      default: load_s = 1'b0;
    endcase
  end

  // Record storage; contents are only read when the level says they are valid.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {src, des_ip};
    end
  end

  // Pointers and record level; a write and a load on the same edge cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {(ADDR_W + 1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, load_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Saturating drop counter and one-cycle overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= drop_s;
      if (drop_s && (drop_cnt_r != DROP_MAX)) begin
        drop_cnt_r <= drop_cnt_r + DROP_ONE;
      end
    end
  end

  // Output FSM: src word, then dst word, reloading straight from S_DST when records wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
      m_data_r   <= 32'h0000_0000;
      dst_hold_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (load_s) begin
            m_data_r   <= head_s[63:32];
            dst_hold_r <= head_s[31:0];
            m_valid_r  <= 1'b1;
            m_last_r   <= 1'b0;
            state_r    <= S_SRC;
          end
        end
        S_SRC: begin
          if (hs_s) begin
            m_data_r <= dst_hold_r;
            m_last_r <= 1'b1;
            state_r  <= S_DST;
          end
        end
        S_DST: begin
          if (load_s) begin
            m_data_r   <= head_s[63:32];
            dst_hold_r <= head_s[31:0];
            m_valid_r  <= 1'b1;
            m_last_r   <= 1'b0;
            state_r    <= S_SRC;
          end else if (hs_s) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          m_valid_r <= 1'b0;
          m_last_r  <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign m_last     = m_last_r;
  assign fifo_level = level_r;
  assign drop_cnt   = drop_cnt_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_ip_pair_buffer.sv
// Randomized bench for ip_pair_buffer against a queue-based record model; a second instance
// with a 2-bit drop counter exercises saturation.
module tb_ip_pair_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_pkt_done = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] src = 32'h0;
  logic [31:0] des_ip = 32'h0;

  logic        m_valid, m_last, overflow;
  logic [31:0] m_data;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;
  logic        s_m_valid, s_m_last, s_overflow;
  logic [31:0] s_m_data;
  logic [4:0]  s_fifo_level;
  logic [1:0]  s_drop_cnt;

  ip_pair_buffer dut (
    .clk(clk), .rst(rst), .rec_pkt_done(rec_pkt_done), .src(src), .des_ip(des_ip),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  ip_pair_buffer #(.DROP_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rec_pkt_done(rec_pkt_done), .src(src), .des_ip(des_ip),
    .m_valid(s_m_valid), .m_data(s_m_data), .m_last(s_m_last), .m_ready(m_ready),
    .fifo_level(s_fifo_level), .drop_cnt(s_drop_cnt), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored records plus the one record held in the output stage.
  logic [63:0] mq[$];
  bit          st_v;
  bit          st_half;
  logic [63:0] st_rec;
  int          drops;
  bit          ovf_exp;

  wire [97:0] obs_s = {m_valid, m_last, (m_valid ? m_data : 32'h0), fifo_level, drop_cnt,
                       overflow, s_drop_cnt, s_overflow, s_m_valid, s_m_last,
                       (s_m_valid ? s_m_data : 32'h0), s_fifo_level};

  function automatic logic [97:0] build_exp();
    logic [31:0] ed;
    int d16;
    int d2;
    ed  = st_v ? (st_half ? st_rec[31:0] : st_rec[63:32]) : 32'h0;
    d16 = (drops > 65535) ? 65535 : drops;
    d2  = (drops > 3) ? 3 : drops;
    return {st_v, st_v && st_half, ed, 5'(mq.size()), 16'(d16), ovf_exp, 2'(d2), ovf_exp,
            st_v, st_v && st_half, ed, 5'(mq.size())};
  endfunction

  task automatic model_clear();
    mq.delete();
    st_v = 1'b0; st_half = 1'b0; st_rec = 64'h0; drops = 0; ovf_exp = 1'b0;
  endtask

  task automatic model_step();
    bit hs;
    bit full;
    bit load;
    hs   = st_v && m_ready;
    full = (mq.size() == DEPTH);
    load = (mq.size() != 0) && (!st_v || (hs && st_half));
    if (load) begin
      st_rec = mq.pop_front(); st_v = 1'b1; st_half = 1'b0;
    end else if (hs && !st_half) begin
      st_half = 1'b1;
    end else if (hs) begin
      st_v = 1'b0; st_half = 1'b0;
    end
    ovf_exp = 1'b0;
    if (rec_pkt_done) begin
      if (full) begin
        drops++; ovf_exp = 1'b1;
      end else begin
        mq.push_back({src, des_ip});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rec_pkt_done = 1'b0; m_ready = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    #2;
    checks++;
    if ({m_valid, m_last, m_data, fifo_level, drop_cnt, overflow} !== 55'h0) begin
      errors++;
      $display("FAIL reset_vals got v=%b l=%b d=%h lvl=%0d drop=%0d ovf=%b want all 0",
               m_valid, m_last, m_data, fifo_level, drop_cnt, overflow);
    end
    checks++;
    if (obs_s !== build_exp()) begin
      errors++; $display("FAIL reset_model got %h want %h", obs_s, build_exp());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    rec_pkt_done = 1'b1; src = 32'hC0A8010A; des_ip = 32'hC0A80102; m_ready = 1'b1;
    tick();
    rec_pkt_done = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL single_lat_e got m_valid=%b want 0", m_valid);
    end
    tick();
    checks++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 32'hC0A8010A}) begin
      errors++; $display("FAIL single_src got v=%b l=%b d=%h want v=1 l=0 d=c0a8010a",
                         m_valid, m_last, m_data);
    end
    tick();
    checks++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b1, 32'hC0A80102}) begin
      errors++; $display("FAIL single_dst got v=%b l=%b d=%h want v=1 l=1 d=c0a80102",
                         m_valid, m_last, m_data);
    end
    tick();
    checks++;
    if ({m_valid, fifo_level} !== {1'b0, 5'd0}) begin
      errors++; $display("FAIL single_end got v=%b lvl=%0d want v=0 lvl=0", m_valid, fifo_level);
    end
    checks++;
    if (obs_s !== build_exp()) begin
      errors++; $display("FAIL single_model got %h want %h", obs_s, build_exp());
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] recs [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      recs[i] = {$urandom, $urandom};
      rec_pkt_done = 1'b1; src = recs[i][63:32]; des_ip = recs[i][31:0];
      tick();
    end
    rec_pkt_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_s !== build_exp()) begin
        errors++; $display("FAIL bp_hold cyc %0d got %h want %h", i, obs_s, build_exp());
      end
    end
    checks++;
    if ({m_valid, m_data, fifo_level} !== {1'b1, recs[0][63:32], 5'd2}) begin
      errors++; $display("FAIL bp_stall got v=%b d=%h lvl=%0d want v=1 d=%h lvl=2",
                         m_valid, m_data, fifo_level, recs[0][63:32]);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (m_valid !== 1'b1 || obs_s !== build_exp()) begin
        errors++; $display("FAIL bp_drain word %0d got v=%b %h want %h", i + 1, m_valid,
                           obs_s, build_exp());
      end
    end
    checks++;
    if (m_data !== recs[2][31:0] || m_last !== 1'b1) begin
      errors++; $display("FAIL bp_last got d=%h l=%b want d=%h l=1", m_data, m_last, recs[2][31:0]);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle got m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_overflow();
    int ovf_seen = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rec_pkt_done = (i < 19); src = $urandom; des_ip = $urandom;
      tick();
      if (overflow === 1'b1) ovf_seen++;
      checks++;
      if (obs_s !== build_exp()) begin
        errors++; $display("FAIL ovf_fill cyc %0d got %h want %h", i, obs_s, build_exp());
      end
    end
    rec_pkt_done = 1'b0;
    checks++;
    if (fifo_level !== 5'd16 || drop_cnt !== 16'd2 || ovf_seen != 2) begin
      errors++; $display("FAIL ovf_counts got lvl=%0d drop=%0d pulses=%0d want 16 2 2",
                         fifo_level, drop_cnt, ovf_seen);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs_s !== build_exp()) begin
        errors++; $display("FAIL ovf_drain cyc %0d got %h want %h", i, obs_s, build_exp());
      end
    end
    checks++;
    if ({m_valid, fifo_level} !== {1'b0, 5'd0}) begin
      errors++; $display("FAIL ovf_empty got v=%b lvl=%0d want 0 0", m_valid, fifo_level);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      rec_pkt_done = 1'b1; src = $urandom; des_ip = $urandom;
      tick();
    end
    rec_pkt_done = 1'b0;
    m_ready = 1'b1;
    tick();
    checks++;
    if ({m_last, fifo_level, drop_cnt} !== {1'b1, 5'd16, 16'd1}) begin
      errors++; $display("FAIL simul_pre got l=%b lvl=%0d drop=%0d want 1 16 1",
                         m_last, fifo_level, drop_cnt);
    end
    rec_pkt_done = 1'b1; src = $urandom; des_ip = $urandom;
    tick();
    rec_pkt_done = 1'b0;
    checks++;
    if ({fifo_level, drop_cnt, overflow} !== {5'd15, 16'd2, 1'b1}) begin
      errors++; $display("FAIL simul_drop got lvl=%0d drop=%0d ovf=%b want 15 2 1",
                         fifo_level, drop_cnt, overflow);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs_s !== build_exp()) begin
        errors++; $display("FAIL simul_drain cyc %0d got %h want %h", i, obs_s, build_exp());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rec_pkt_done = 1'b1; src = $urandom; des_ip = $urandom;
      tick();
    end
    rec_pkt_done = 1'b0;
    m_ready = 1'b1;
    tick();
    checks++;
    if ({m_last, fifo_level} !== {1'b1, 5'd5}) begin
      errors++; $display("FAIL rmid_pre got l=%b lvl=%0d want 1 5", m_last, fifo_level);
    end
    m_ready = 1'b0;
    rst = 1'b1;
    model_clear();
    #2;
    checks++;
    if ({m_valid, m_last, m_data, fifo_level, drop_cnt, overflow} !== 55'h0) begin
      errors++; $display("FAIL rmid_async got v=%b l=%b d=%h lvl=%0d drop=%0d want all 0",
                         m_valid, m_last, m_data, fifo_level, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    rec_pkt_done = 1'b1; src = 32'h0A000001; des_ip = 32'h0A000002; m_ready = 1'b1;
    tick();
    rec_pkt_done = 1'b0;
    tick();
    checks++;
    if ({m_valid, m_last, m_data, fifo_level} !== {1'b1, 1'b0, 32'h0A000001, 5'd0}) begin
      errors++; $display("FAIL rmid_fresh got v=%b l=%b d=%h lvl=%0d want 1 0 0a000001 0",
                         m_valid, m_last, m_data, fifo_level);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_s !== build_exp()) begin
        errors++; $display("FAIL rmid_model cyc %0d got %h want %h", i, obs_s, build_exp());
      end
    end
  endtask

  task automatic test_saturation();
    int ovf_seen = 0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      rec_pkt_done = (i < 23); src = $urandom; des_ip = $urandom;
      tick();
      if (s_overflow === 1'b1) ovf_seen++;
    end
    rec_pkt_done = 1'b0;
    checks++;
    if (s_drop_cnt !== 2'd3 || drop_cnt !== 16'd6 || ovf_seen != 6) begin
      errors++; $display("FAIL sat_cnt got sat=%0d drop=%0d pulses=%0d want 3 6 6",
                         s_drop_cnt, drop_cnt, ovf_seen);
    end
    checks++;
    if (obs_s !== build_exp()) begin
      errors++; $display("FAIL sat_model got %h want %h", obs_s, build_exp());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rec_pkt_done = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 70 : 30));
      m_ready = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 85));
      src = $urandom; des_ip = $urandom;
      tick();
      checks++;
      if (obs_s !== build_exp()) begin
        errors++; $display("FAIL rand cyc %0d got %h want %h", i, obs_s, build_exp());
      end
    end
    rec_pkt_done = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs_s !== build_exp()) begin
        errors++; $display("FAIL rand_drain cyc %0d got %h want %h", i, obs_s, build_exp());
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
